// File: rtl/output_sa_ctrl.sv
// Switch-allocation controller for one router output port: round-robin grant with wormhole lock,
// credit and GoPhit gating. Define OUTPUT_SA_WATCHDOG_EN to add per-VC stuck-lock detection (wdog_stuck).
module output_sa_ctrl #(
  parameter int NUM_VN_X_VC = 3,
  parameter int NUM_PORTS   = 5,
  parameter int CREDITS     = 4,
  parameter int WDOG_LIMIT  = 1023
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [NUM_PORTS*NUM_VN_X_VC-1:0]              req,
  input  logic [2*NUM_PORTS*NUM_VN_X_VC-1:0]            req_type,
  input  logic                                          go_phit,
  input  logic [NUM_VN_X_VC-1:0]                        credit_in,
  output logic [NUM_PORTS*NUM_VN_X_VC-1:0]              grants,
  output logic [((NUM_VN_X_VC > 1) ? $clog2(NUM_VN_X_VC) : 1)-1:0] vc_selected,
  output logic [NUM_VN_X_VC-1:0]                        vc_locked,
  output logic                                          credit_err
`ifdef OUTPUT_SA_WATCHDOG_EN
  ,
  output logic [NUM_VN_X_VC-1:0]                        wdog_stuck
`endif
);

  localparam int NREQ   = NUM_PORTS * NUM_VN_X_VC;
  localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int VC_W   = (NUM_VN_X_VC > 1) ? $clog2(NUM_VN_X_VC) : 1;
  localparam int CRED_W = $clog2(CREDITS + 1);

  localparam logic [1:0] FLIT_BODY        = 2'b00;
  localparam logic [1:0] FLIT_TAIL        = 2'b01;
  localparam logic [1:0] FLIT_HEADER      = 2'b10;
  localparam logic [1:0] FLIT_HEADER_TAIL = 2'b11;

  logic [NUM_VN_X_VC-1:0] lock_q, lock_d;
  logic [PTR_W-1:0]       owner_q [NUM_VN_X_VC];
  logic [PTR_W-1:0]       owner_d [NUM_VN_X_VC];
  logic [CRED_W-1:0]      cred_q  [NUM_VN_X_VC];
  logic [CRED_W-1:0]      cred_d  [NUM_VN_X_VC];
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   credit_err_q, credit_err_d;

  logic [NREQ-1:0]        elig;
  logic                   gnt_vld;
  logic [PTR_W-1:0]       gnt_idx;
  logic [VC_W-1:0]        gnt_vc;
  logic [1:0]             gnt_type;
  logic [NUM_VN_X_VC-1:0] gnt_on_vc;

  // A free VC accepts only packet-opening flits; a locked VC accepts only its owner.
  always_comb begin
    elig = '0;
    for (int r = 0; r < NREQ; r++) begin
      elig[r] = req[r] && go_phit && (cred_q[r % NUM_VN_X_VC] != '0) &&
                ((!lock_q[r % NUM_VN_X_VC] &&
                  ((req_type[2*r +: 2] == FLIT_HEADER) || (req_type[2*r +: 2] == FLIT_HEADER_TAIL))) ||
                 (lock_q[r % NUM_VN_X_VC] && (owner_q[r % NUM_VN_X_VC] == PTR_W'(r))));
    end
  end

  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
  end

  assign gnt_vc   = VC_W'(int'(gnt_idx) % NUM_VN_X_VC);
  assign gnt_type = req_type[2*gnt_idx +: 2];

  assign grants      = (rst_n && gnt_vld) ? (NREQ'(1) << gnt_idx) : '0;
  assign vc_selected = (rst_n && gnt_vld) ? gnt_vc : '0;
  assign vc_locked   = lock_q;
  assign credit_err  = credit_err_q;

  always_comb begin
    lock_d       = lock_q;
    owner_d      = owner_q;
    cred_d       = cred_q;
    rr_ptr_d     = rr_ptr_q;
    credit_err_d = credit_err_q;
    gnt_on_vc    = '0;
    if (gnt_vld) begin
      gnt_on_vc[gnt_vc] = 1'b1;
      rr_ptr_d = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      case (gnt_type)
        FLIT_HEADER: begin
          lock_d[gnt_vc]  = 1'b1;
          owner_d[gnt_vc] = gnt_idx;
        end
        FLIT_TAIL: lock_d[gnt_vc] = 1'b0;
        default: ;
      endcase
    end
    // A grant and a returning credit in the same cycle cancel out.
    for (int v = 0; v < NUM_VN_X_VC; v++) begin
      if (gnt_on_vc[v] && !credit_in[v]) begin
        cred_d[v] = cred_q[v] - 1'b1;
      end else if (!gnt_on_vc[v] && credit_in[v]) begin
        if (cred_q[v] == CRED_W'(CREDITS)) credit_err_d = 1'b1;
        else cred_d[v] = cred_q[v] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q       <= '0;
      rr_ptr_q     <= '0;
      credit_err_q <= 1'b0;
      for (int v = 0; v < NUM_VN_X_VC; v++) begin
        owner_q[v] <= '0;
        cred_q[v]  <= CRED_W'(CREDITS);
      end
    end else begin
      lock_q       <= lock_d;
      rr_ptr_q     <= rr_ptr_d;
      credit_err_q <= credit_err_d;
      for (int v = 0; v < NUM_VN_X_VC; v++) begin
        owner_q[v] <= owner_d[v];
        cred_q[v]  <= cred_d[v];
      end
    end
  end

`ifdef OUTPUT_SA_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);

  logic [WD_W-1:0] wdog_q [NUM_VN_X_VC];
  logic [WD_W-1:0] wdog_d [NUM_VN_X_VC];

  // Counts locked cycles without progress; saturates so the flag stays up.
  always_comb begin
    for (int v = 0; v < NUM_VN_X_VC; v++) begin
      if (gnt_on_vc[v] || !lock_q[v]) wdog_d[v] = '0;
      else if (wdog_q[v] == WD_W'(WDOG_LIMIT)) wdog_d[v] = wdog_q[v];
      else wdog_d[v] = wdog_q[v] + 1'b1;
      wdog_stuck[v] = (wdog_q[v] == WD_W'(WDOG_LIMIT));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VN_X_VC; v++) wdog_q[v] <= '0;
    end else begin
      for (int v = 0; v < NUM_VN_X_VC; v++) wdog_q[v] <= wdog_d[v];
    end
  end
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = (WDOG_LIMIT > 0);
`endif

endmodule
